kernel_invoke_arbiter: RTL

//  Shares one ap_start/ap_done kernel instance (e.g. the factorial top) among NUM_REQ requesters.

---
 rtl/kernel_arb_pkg.sv | 19 +
 rtl/rr_arbiter_core.sv | 32 +++
 rtl/kernel_invoke_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/kernel_arb_pkg.sv
// Shared types and helpers for the kernel invocation arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package kernel_arb_pkg;

    // Arbiter control states; encoding is fixed so it can be observed by debug tooling.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Requester-index width; never below one bit so the id ports always exist.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Rotate-priority picker: first asserted request at or after ptr_i, wrapping modulo NUM_REQ.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arbiter_core #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               found_o
);

    // Walk the requesters in priority order starting at the pointer; the first hit wins.
    always_comb begin
        int idx;
        idx     = 0;
        grant_o = '0;
        idx_o   = '0;
        found_o = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr_i) + off) % NUM_REQ;
            if (!found_o && req_i[idx]) begin
                found_o      = 1'b1;
                grant_o[idx] = 1'b1;
                idx_o        = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/kernel_invoke_arbiter.sv
// Shares one ap_start/ap_done kernel among NUM_REQ requesters, one invocation in flight, round-robin.
// Latency: accept at cycle 0, k_ap_start from cycle 1, resp_valid the cycle after k_ap_done.
// Backpressure: holds the result in RESP until resp_ready; no new grant until that handshake.
module kernel_invoke_arbiter
    import kernel_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  ARG_W   = 8,
    parameter int  RES_W   = 8,
    parameter int  CNT_W   = 16,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*ARG_W-1:0] req_arg,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     resp_valid,
    output logic [ID_W-1:0]          resp_id,
    output logic [RES_W-1:0]         resp_data,
    input  logic                     resp_ready,
    output logic                     k_ap_start,
    input  logic                     k_ap_ready,
    output logic [ARG_W-1:0]         k_arg,
    input  logic                     k_ap_done,
    input  logic [RES_W-1:0]         k_result,
    output logic                     busy,
    output logic                     err_spur,
    output logic [CNT_W-1:0]         inv_count
);

    arb_state_e         state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rr_ptr_d;
    logic [ID_W-1:0]    id_q;
    logic [ARG_W-1:0]   arg_q;
    logic [RES_W-1:0]   res_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               start_q;
    logic               rvld_q;
    logic               busy_q;
    logic               err_q;

    logic [NUM_REQ-1:0] gnt_onehot;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_found;
    logic [ARG_W-1:0]   gnt_arg;

    rr_arbiter_core #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt_onehot),
        .idx_o   (gnt_idx),
        .found_o (gnt_found)
    );

    assign gnt_arg = req_arg[gnt_idx*ARG_W +: ARG_W];

    // Pointer moves just past the requester that was served; counter saturates at all-ones.
    always_comb begin
        rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Control FSM with its registered outputs and the argument/id/result holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            arg_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            rvld_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_found) begin
                        arg_q   <= gnt_arg;
                        id_q    <= gnt_idx;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (k_ap_ready) begin
                        start_q <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (k_ap_done) begin
                        res_q   <= k_result;
                        rvld_q  <= 1'b1;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        rvld_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= rr_ptr_d;
                        cnt_q    <= cnt_d;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A done pulse outside RUN means the kernel and arbiter disagree; remember it until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (k_ap_done && (state_q != ST_RUN)) begin
            err_q <= 1'b1;
        end
    end

    // Only the accept strobe is combinational: it is the grant, qualified by being idle.
    assign req_ready  = (state_q == ST_IDLE) ? gnt_onehot : '0;
    assign resp_valid = rvld_q;
    assign resp_id    = id_q;
    assign resp_data  = res_q;
    assign k_ap_start = start_q;
    assign k_arg      = arg_q;
    assign busy       = busy_q;
    assign err_spur   = err_q;
    assign inv_count  = cnt_q;

endmodule
